dbus_arbiter: RTL
=================

# dbus_arbiter

Round-robin arbiter and sequencer that shares one register data bus between N_REQ requesters. Each requester posts a single read or write through a Req/Ack handshake. The arbiter grants one requester at a time and drives the bus slave side (Addr, Dout, Wr, Din) with the standard two-phase cycle: address/data setup, then access. It sits between the bus masters (CPU-side engines, test sequencers) and the register-file slaves.

## Interface
- DATA_WIDTH, 8, bus data width
- ADDR_WIDTH, 8, bus address width
- N_REQ, 2, number of requesters (≥2)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  synchronous reset, active-high
- Req  in  N_REQ  per-requester transaction request (level)
- ReqWr  in  N_REQ  per-requester direction: 1 write, 0 read
- ReqAddr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- ReqData  in  N_REQ*DATA_WIDTH  packed write data, same packing
- Ack  out  N_REQ  one-cycle completion pulse to the granted requester
- Grant  out  N_REQ  one-hot owner of the bus; all zero when idle
- RdData  out  DATA_WIDTH  read data from the last completed read
- Addr  out  ADDR_WIDTH  bus address
- Dout  out  DATA_WIDTH  bus write data
- Din  in  DATA_WIDTH  bus read data from slaves
- Wr  out  1  bus write strobe

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any Req bit is high, pick the winner by round-robin, starting from the index after LastGrant.
  - Latch the winner's ReqWr, ReqAddr and ReqData into internal registers.
  - Set Grant to the winner and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - Addr and Dout = latched values; Wr=0.
  - For reads, Dout=0.
  - Go to ACCESS.
- ACCESS:
  - Addr and Dout held; Wr=1 if latched direction is write, else Wr=0.
  - Go to DONE.
  - For a read, RdData <= Din on the edge leaving ACCESS.
- DONE:
  - Ack[winner]=1; Addr, Dout and Wr all 0; Grant still valid.
  - LastGrant <= winner.
  - Go to IDLE.
- Round-robin: the search order is LastGrant+1, LastGrant+2, … modulo N_REQ. At reset LastGrant = N_REQ-1, so requester 0 has first priority.
- Requester rules:
  - Req must stay high until the grant edge. Address, data and direction are sampled only on that edge, so they may change afterward.
  - Req dropped before it is granted: no transaction for that requester.
  - Req dropped after the grant: the transaction still completes and Ack still pulses.
  - Req still high on the edge ending DONE counts as a new request; it is arbitrated in the next IDLE cycle.
- RdData changes only at the ACCESS→DONE edge of a read. It holds its value across writes and idle cycles.
- Reset values: state IDLE, LastGrant=N_REQ-1, and Ack, Grant, RdData, Addr, Dout, Wr all 0.

## Timing
- The grant is sampled at edge E0 while in IDLE.
- Cycle after E0 (SETUP): Grant valid, Addr/Dout valid, Wr=0.
- Cycle after E1 (ACCESS): Wr=1 for a write; a read samples Din at E2.
- Cycle after E2 (DONE): Ack pulse; RdData valid for a read; bus returns to zero.
- Cycle after E3: IDLE, earliest next arbitration. Sustained throughput is one transaction every 4 cycles.
- Latency from Req rise (in IDLE) to Ack is 3 cycles.
- Wr is high for exactly one cycle per write, and only while Addr/Dout are stable. It never coincides with an address change.
- Simultaneous requests: exactly one grant; the others wait and are served in round-robin order.
- Rst high at any edge returns to IDLE with outputs zeroed on the next cycle. An in-flight transaction is aborted: no Ack, Wr low. LastGrant is reinitialised.
- Rst has priority over every FSM transition.

## Test plan
- Single write: Req[0]=1, ReqWr[0]=1, ReqAddr[0]=0x12, ReqData[0]=0xA5. Expected:
  - SETUP: Addr=0x12, Dout=0xA5, Wr=0.
  - ACCESS: Wr=1.
  - DONE: Ack=01, bus zero.
- Single read: Req[1]=1, ReqWr[1]=0, ReqAddr[1]=0x34, slave drives Din=0x5C. Expected: Wr never asserted; Ack=10 in DONE; RdData=0x5C, held through a following write.
- Contention: both Req held high continuously after reset. Expected grants 0,1,0,1; each Ack spaced 4 cycles apart; the Grant one-hot never has two bits set.
- Late request: Req[1] rises while requester 0 is in ACCESS. Expected: requester 1 granted at the first IDLE after requester 0's DONE.
- Withdrawn request: Req[0] pulsed during another requester's transaction and dropped before IDLE. Expected: no grant and no Ack for requester 0.
- Reset mid-write: Rst=1 during ACCESS. Expected:
  - Next cycle: Wr=0, Addr=0, Grant=0, no Ack.
  - After reset release with both Req high: requester 0 is granted first.

Source files
------------

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter and two-phase bus sequencer.
// N_REQ requesters each post one read or write through a Req/Ack handshake.
// The winner owns the register bus for one SETUP/ACCESS/DONE sequence.
// Every output is registered.
module dbus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [N_REQ-1:0]            Req,
    input  logic [N_REQ-1:0]            ReqWr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] ReqAddr,
    input  logic [N_REQ*DATA_WIDTH-1:0] ReqData,
    output logic [N_REQ-1:0]            Ack,
    output logic [N_REQ-1:0]            Grant,
    output logic [DATA_WIDTH-1:0]       RdData,
    output logic [ADDR_WIDTH-1:0]       Addr,
    output logic [DATA_WIDTH-1:0]       Dout,
    input  logic [DATA_WIDTH-1:0]       Din,
    output logic                        Wr
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Registered state and outputs
    state_t                r_state;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      r_win;
    logic                  r_wr;
    logic [N_REQ-1:0]      r_ack;
    logic [N_REQ-1:0]      r_grant;
    logic [DATA_WIDTH-1:0] r_rddata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_wrstb;

    // Arbitration results
    logic                  w_found;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_cand;
    logic [N_REQ-1:0]      w_win_oh;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_wr;

    // Next-state values
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      w_last_nxt;
    logic [IDX_W-1:0]      w_win_nxt;
    logic                  w_wr_nxt;
    logic [N_REQ-1:0]      w_ack_nxt;
    logic [N_REQ-1:0]      w_grant_nxt;
    logic [DATA_WIDTH-1:0] w_rddata_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_wrstb_nxt;

    assign Ack    = r_ack;
    assign Grant  = r_grant;
    assign RdData = r_rddata;
    assign Addr   = r_addr;
    assign Dout   = r_dout;
    assign Wr     = r_wrstb;

    // Round-robin search: first active Req starting one past the last owner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((32'(r_last) + k) % N_REQ);
            if (!w_found && Req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Select the winner's direction, address and data; build its one-hot grant
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_wr   = 1'b0;
        w_win_oh   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_sel_addr  = ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data  = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wr    = ReqWr[i];
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Next state and next registered outputs; the bus defaults to all-zero
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_win_nxt    = r_win;
        w_wr_nxt     = r_wr;
        w_grant_nxt  = r_grant;
        w_rddata_nxt = r_rddata;
        w_ack_nxt    = '0;
        w_addr_nxt   = '0;
        w_dout_nxt   = '0;
        w_wrstb_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_state_nxt = SETUP;
                    w_grant_nxt = w_win_oh;
                    w_win_nxt   = w_win;
                    w_wr_nxt    = w_sel_wr;
                    w_addr_nxt  = w_sel_addr;
                    // Reads put zero on the write-data lines
                    w_dout_nxt  = w_sel_wr ? w_sel_data : '0;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_addr_nxt  = r_addr;
                w_dout_nxt  = r_dout;
                w_wrstb_nxt = r_wr;
            end
            ACCESS: begin
                w_state_nxt = DONE;
                w_ack_nxt   = r_grant;
                if (!r_wr) begin
                    w_rddata_nxt = Din;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_last_nxt  = r_win;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_last   <= LAST_RST;
            r_win    <= '0;
            r_wr     <= 1'b0;
            r_ack    <= '0;
            r_grant  <= '0;
            r_rddata <= '0;
            r_addr   <= '0;
            r_dout   <= '0;
            r_wrstb  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_win    <= w_win_nxt;
            r_wr     <= w_wr_nxt;
            r_ack    <= w_ack_nxt;
            r_grant  <= w_grant_nxt;
            r_rddata <= w_rddata_nxt;
            r_addr   <= w_addr_nxt;
            r_dout   <= w_dout_nxt;
            r_wrstb  <= w_wrstb_nxt;
        end
    end

endmodule
